// File: rtl/time_entry.sv
// time_entry: keypad M:SS entry, validation and timer load/run control for the microwave.
// Optional feature: define TIME_ENTRY_QUICKSTART_EN for start-in-IDLE (0:30) and +30 s while running.
module time_entry (
    input  logic       clk,
    input  logic       clrn,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       tick,
    input  logic       timer_zero,
    output logic [3:0] d_min,
    output logic [3:0] d_sec_tens,
    output logic [3:0] d_sec_ones,
    output logic       loadn,
    output logic       tim_en,
    output logic       busy,
    output logic       done,
    output logic       err
);
    typedef enum logic [2:0] {IDLE, ENTRY, LOAD, RUN, PAUSE} state_t;

    state_t     state, nstate;
    logic [1:0] cnt, n_cnt;
    logic [3:0] n_min, n_tens, n_ones;
    logic       n_err, n_done;
    logic       tz, key_bad, entry_zero;

    // Completion only counts while running; a zero timer is the normal resting value elsewhere.
    assign tz         = timer_zero && state == RUN;
    // A key that is illegal, overflows the entry, would push >5 into seconds-tens, or arrives while busy.
    assign key_bad    = key_code > 4'd9 || cnt == 2'd3 || (cnt != 2'd0 && d_sec_ones > 4'd5) ||
                        !(state == IDLE || state == ENTRY);
    assign entry_zero = d_min == 4'd0 && d_sec_tens == 4'd0 && d_sec_ones == 4'd0;

`ifdef TIME_ENTRY_QUICKSTART_EN
    logic [3:0] sum_tens;
    logic       carry, sat;
    assign sum_tens = d_sec_tens + 4'd3;
    assign carry    = sum_tens > 4'd5;
    assign sat      = carry && d_min == 4'd9;
`endif

    // State, entry register and the registered err/done pulses.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            d_min      <= 4'd0;
            d_sec_tens <= 4'd0;
            d_sec_ones <= 4'd0;
            err        <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= nstate;
            cnt        <= n_cnt;
            d_min      <= n_min;
            d_sec_tens <= n_tens;
            d_sec_ones <= n_ones;
            err        <= n_err;
            done       <= n_done;
        end
    end

    // Next state with strobe priority clear > timer_zero > stop > start > key.
    always_comb begin
        nstate = (state == LOAD) ? RUN : state;
        n_cnt  = cnt;
        n_min  = d_min;
        n_tens = d_sec_tens;
        n_ones = d_sec_ones;
        n_err  = 1'b0;
        n_done = 1'b0;
        if (clear || tz) begin
            nstate = IDLE;
            n_cnt  = 2'd0;
            n_min  = 4'd0;
            n_tens = 4'd0;
            n_ones = 4'd0;
            n_done = !clear;
        end else if (stop) begin
            if (state == RUN)
                nstate = PAUSE;
        end else if (start) begin
            case (state)
                IDLE: begin
`ifdef TIME_ENTRY_QUICKSTART_EN
                    nstate = LOAD;
                    n_cnt  = 2'd3;
                    n_min  = 4'd0;
                    n_tens = 4'd3;
                    n_ones = 4'd0;
`else
                    n_err  = 1'b1;
`endif
                end
                ENTRY: begin
                    nstate = entry_zero ? IDLE : LOAD;
                    n_cnt  = entry_zero ? 2'd0 : cnt;
                    n_err  = entry_zero;
                end
                PAUSE: nstate = RUN;
`ifdef TIME_ENTRY_QUICKSTART_EN
                RUN: begin
                    nstate = LOAD;
                    n_min  = sat ? 4'd9 : (carry ? d_min + 4'd1 : d_min);
                    n_tens = sat ? 4'd5 : (carry ? sum_tens - 4'd6 : sum_tens);
                    n_ones = sat ? 4'd9 : d_sec_ones;
                end
`endif
                default: ;
            endcase
        end else if (key_valid) begin
            if (key_bad) begin
                n_err = 1'b1;
            end else begin
                nstate = ENTRY;
                n_cnt  = cnt + 2'd1;
                n_min  = d_sec_tens;
                n_tens = d_sec_ones;
                n_ones = key_code;
            end
        end
    end

    // Timer interface decoded from state; only tim_en follows tick combinationally in RUN.
    always_comb begin
        loadn  = state != LOAD;
        tim_en = state == LOAD || (state == RUN && tick);
        busy   = state == LOAD || state == RUN || state == PAUSE;
    end
endmodule

// File: tb/tb_time_entry.sv
// tb_time_entry: directed stimulus against an arithmetic model of the time entry block.
module tb_time_entry;
    logic       clk = 0, clrn = 0;
    logic       key_valid = 0, start = 0, stop = 0, clear = 0, tick = 0, timer_zero = 0;
    logic [3:0] key_code = 0;
    logic [3:0] d_min, d_sec_tens, d_sec_ones;
    logic       loadn, tim_en, busy, done, err;
    int         checks = 0, passed = 0;
    logic       armed = 0;

    time_entry dut (
        .clk(clk), .clrn(clrn), .key_valid(key_valid), .key_code(key_code),
        .start(start), .stop(stop), .clear(clear), .tick(tick), .timer_zero(timer_zero),
        .d_min(d_min), .d_sec_tens(d_sec_tens), .d_sec_ones(d_sec_ones),
        .loadn(loadn), .tim_en(tim_en), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 entry, 2 load, 3 run, 4 pause; entry held as the decimal number MSS.
    int m_mode = 0, m_val = 0, m_cnt = 0;
    logic e_err = 0, e_done = 0;

    always @(posedge clk or negedge clrn) begin
        int s;
        bit was_load;
        if (!clrn) begin
            m_mode = 0; m_val = 0; m_cnt = 0; e_err = 0; e_done = 0;
        end else begin
            e_err = 0; e_done = 0;
            was_load = (m_mode == 2);
            if (clear) begin
                m_mode = 0; m_val = 0; m_cnt = 0;
            end else if (timer_zero && m_mode == 3) begin
                m_mode = 0; m_val = 0; m_cnt = 0; e_done = 1;
            end else if (stop) begin
                if (m_mode == 3) m_mode = 4;
            end else if (start) begin
                if (m_mode == 0) begin
`ifdef TIME_ENTRY_QUICKSTART_EN
                    m_val = 30; m_cnt = 3; m_mode = 2;
`else
                    e_err = 1;
`endif
                end else if (m_mode == 1) begin
                    if (m_val == 0) begin e_err = 1; m_mode = 0; m_cnt = 0; end
                    else m_mode = 2;
                end else if (m_mode == 4) begin
                    m_mode = 3;
                end else if (m_mode == 3) begin
`ifdef TIME_ENTRY_QUICKSTART_EN
                    s = (m_val / 100) * 60 + m_val % 100 + 30;
                    if (s > 599) s = 599;
                    m_val = (s / 60) * 100 + s % 60;
                    m_mode = 2;
`endif
                end
            end else if (key_valid) begin
                if (key_code > 9 || m_cnt == 3 || (m_cnt > 0 && m_val % 10 > 5) || m_mode > 1)
                    e_err = 1;
                else begin
                    m_val = (m_val * 10 + int'(key_code)) % 1000;
                    m_cnt++;
                    m_mode = 1;
                end
            end
            if (was_load && m_mode == 2) m_mode = 3;
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else passed++;
    endtask

    // Every cycle, away from the clock edge, compare all outputs with the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("d_min", {12'd0, d_min}, 16'(m_val / 100));
            chk("d_sec_tens", {12'd0, d_sec_tens}, 16'((m_val / 10) % 10));
            chk("d_sec_ones", {12'd0, d_sec_ones}, 16'(m_val % 10));
            chk("loadn", {15'd0, loadn}, {15'd0, m_mode != 2});
            chk("tim_en", {15'd0, tim_en}, {15'd0, m_mode == 2 || (m_mode == 3 && tick)});
            chk("busy", {15'd0, busy}, {15'd0, m_mode >= 2});
            chk("done", {15'd0, done}, {15'd0, e_done});
            chk("err", {15'd0, err}, {15'd0, e_err});
        end
    end

    task automatic step(input logic kv, input logic [3:0] kc, input logic st, input logic sp,
                        input logic cl, input logic tk, input logic tz);
        key_valid = kv; key_code = kc; start = st; stop = sp; clear = cl; tick = tk; timer_zero = tz;
        @(posedge clk);
        #1;
        key_valid = 0; key_code = 0; start = 0; stop = 0; clear = 0; tick = 0; timer_zero = 0;
    endtask

    task automatic key(input logic [3:0] k);
        step(1, k, 0, 0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic digits(input string nm, input logic [11:0] exp);
        chk(nm, {4'd0, d_min, d_sec_tens, d_sec_ones}, {4'd0, exp});
    endtask

    initial begin
        @(posedge clk);
        #1;
        armed = 1;
        digits("reset_digits", 12'h000);
        chk("reset_loadn", {15'd0, loadn}, 16'd1);
        chk("reset_busy", {15'd0, busy}, 16'd0);
        clrn = 1;
        idle(1);
        // 1,3,0 then start
        key(1); key(3); key(0);
        digits("entry_130", 12'h130);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("load_loadn", {15'd0, loadn}, 16'd0);
        chk("load_busy", {15'd0, busy}, 16'd1);
        idle(1);
        chk("run_loadn", {15'd0, loadn}, 16'd1);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, i % 4 == 3, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("resume_loadn", {15'd0, loadn}, 16'd1);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("done_pulse", {15'd0, done}, 16'd1);
        digits("done_digits", 12'h000);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("done_single", {15'd0, done}, 16'd0);
        // timer_zero in IDLE must not block a key
        step(1, 4'd7, 0, 0, 0, 0, 1);
        key(2);
        chk("reject_72_err", {15'd0, err}, 16'd1);
        digits("reject_72", 12'h007);
        step(0, 0, 0, 0, 1, 0, 0);
        key(4); key(5); key(9); key(1);
        chk("overflow_err", {15'd0, err}, 16'd1);
        digits("overflow_459", 12'h459);
        step(0, 0, 1, 0, 1, 0, 0);
        chk("clear_start_busy", {15'd0, busy}, 16'd0);
        digits("clear_start", 12'h000);
        key(4'd12);
        chk("illegal_key_err", {15'd0, err}, 16'd1);
        key(0); key(0);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("zero_start_err", {15'd0, err}, 16'd1);
        // start with key in same cycle: key dropped
        key(2); step(1, 4'd3, 1, 0, 0, 0, 0);
        digits("start_drops_key", 12'h002);
        idle(3);
        key(5);
        chk("key_in_run_err", {15'd0, err}, 16'd1);
        clrn = 0;
        #1;
        chk("clrn_busy", {15'd0, busy}, 16'd0);
        chk("clrn_tim_en", {15'd0, tim_en}, 16'd0);
        digits("clrn_digits", 12'h000);
        @(posedge clk);
        #1;
        clrn = 1;
        idle(1);
        step(0, 0, 1, 0, 0, 0, 0);
`ifdef TIME_ENTRY_QUICKSTART_EN
        chk("qs_idle_loadn", {15'd0, loadn}, 16'd0);
        digits("qs_idle_030", 12'h030);
`else
        chk("idle_start_err", {15'd0, err}, 16'd1);
`endif
        step(0, 0, 0, 0, 1, 0, 0);
        key(4); key(5);
        step(0, 0, 1, 0, 0, 0, 0);
        idle(2);
        step(0, 0, 1, 0, 0, 0, 0);
`ifdef TIME_ENTRY_QUICKSTART_EN
        chk("qs_run_loadn", {15'd0, loadn}, 16'd0);
        digits("qs_run_115", 12'h115);
`else
        chk("run_start_loadn", {15'd0, loadn}, 16'd1);
        digits("run_start_045", 12'h045);
`endif
        idle(2);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(2);
        armed = 0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/time_entry.md
# time_entry

Keypad time-entry and timer control block for the microwave. It collects up to three BCD digits (M:SS) from the keypad and validates the seconds-tens digit against the mod-6 range. On start it drives the parallel `data`/`loadn`/`en` load interface of the timer digit chain. During cooking it gates the 1 Hz tick into the timer enable, and handles pause, cancel and completion using the chain's combined zero flag.

## Interface
- No parameters.
- `clk` in 1 — system clock.
- `clrn` in 1 — reset, asynchronous, active-low.
- `key_valid` in 1 — one-cycle strobe; `key_code` valid.
- `key_code` in 4 — BCD digit 0–9; values 10–15 are illegal.
- `start` in 1 — one-cycle strobe: start or resume.
- `stop` in 1 — one-cycle strobe: pause.
- `clear` in 1 — one-cycle strobe: cancel and clear the entry.
- `tick` in 1 — one-cycle 1 Hz strobe.
- `timer_zero` in 1 — AND of the `zero` flags of all timer digits.
- `d_min` out 4 — minutes digit to the timer `data`.
- `d_sec_tens` out 4 — seconds-tens digit to the mod-6 `data`; always 0–5.
- `d_sec_ones` out 4 — seconds-ones digit to the timer `data`.
- `loadn` out 1 — active-low load, shared by all timer digits.
- `tim_en` out 1 — timer enable.
- `busy` out 1 — high in LOAD, RUN and PAUSE.
- `done` out 1 — one-cycle completion pulse.
- `err` out 1 — one-cycle rejected-input pulse.

## Operation
- States:
  - IDLE: entry empty.
  - ENTRY: 1–3 digits held.
  - LOAD
  - RUN
  - PAUSE
- Entry register: `d_min`, `d_sec_tens`, `d_sec_ones`, plus a digit count `cnt` (0–3).
- Accepted key, allowed in IDLE or ENTRY:
  - The register shifts left: `d_min`←`d_sec_tens`, `d_sec_tens`←`d_sec_ones`, `d_sec_ones`←`key_code`.
  - `cnt` increments.
  - The state goes to ENTRY.
- A key is rejected, with `err`=1 and no register change, if any of these hold:
  - `key_code` > 9;
  - `cnt` = 3;
  - the shift would move a value > 5 into `d_sec_tens` (i.e. `cnt` ≥ 1 and `d_sec_ones` > 5);
  - the state is LOAD, RUN or PAUSE.
- `start` in ENTRY:
  - Entry nonzero → LOAD.
  - Entry all-zero → `err`=1, then clear to IDLE.
- LOAD lasts exactly 1 cycle with `loadn`=0 and `tim_en`=1, then goes to RUN. Digits stay on the `d_*` outputs, unchanged, throughout LOAD, RUN and PAUSE.
- RUN:
  - `tim_en` = `tick`.
  - `stop` → PAUSE.
  - `timer_zero`=1 → IDLE, with `done`=1 for one cycle and the entry cleared.
- PAUSE:
  - `tim_en`=0.
  - `start` → RUN, with no reload.
  - `clear` → IDLE.
- `clear` in any state → IDLE: digits 0, `cnt` 0, `loadn`=1, `tim_en`=0.
- Priority within a cycle: `clear` > `timer_zero` > `stop` > `start` > `key_valid`. A lower-priority strobe in the same cycle is dropped silently, with no `err`.
- `timer_zero` is ignored outside RUN.

## Timing
- Reset values:
  - state IDLE;
  - `d_*` = 0, `cnt` = 0;
  - `loadn`=1, `tim_en`=0;
  - `busy`=0, `done`=0, `err`=0.
- All outputs are registered; there are no combinational paths from inputs to outputs, except `tim_en` = `tick` in RUN.
- Key to updated digits: 1 cycle.
- `start` to `loadn`=0: 1 cycle. `loadn` stays low for exactly 1 cycle.
- `timer_zero` is first evaluated in the cycle after LOAD. Because zero entries are never loaded, there is no false completion.
- `timer_zero` to `done`: 1 cycle.
- `err` and `done` are single-cycle pulses, even if the cause persists.
- `clrn` asserted mid-RUN forces the reset values immediately, with no `done`.

## Configuration
- Macro: `TIME_ENTRY_QUICKSTART_EN`.
- Defined:
  - `start` in IDLE loads 0:30 (`d_min`=0, `d_sec_tens`=3, `d_sec_ones`=0, `cnt`=3) and goes to LOAD.
  - `start` in RUN adds 30 s: seconds-tens carries mod 6 into minutes, with minutes saturating at 9:59. This is followed by a LOAD cycle.
- Undefined:
  - `start` in IDLE → `err`=1.
  - `start` in RUN is ignored.

## Test plan
- Keys 1,3,0 then `start` → `d_*`=1/3/0; `loadn` low for 1 cycle, 1 cycle after `start`; `busy`=1.
- Keys 7,2 → second key rejected: `err`=1, `d_sec_ones` stays 7, `d_sec_tens` stays 0.
- Keys 4,5,9,1 → fourth key rejected: `err`=1; digits stay 4:59.
- RUN with `tick` every 4 cycles → `tim_en` mirrors `tick`. `stop` gives `tim_en`=0. `start` resumes without `loadn`. Raising `timer_zero` gives `done` for 1 cycle, then IDLE with digits 0.
- `clear` and `start` in the same cycle during ENTRY → IDLE, no load. `clrn` pulse mid-RUN gives reset values immediately.
- Macro defined: `start` in IDLE → load 0:30. `start` again in RUN at 0:45 → load 1:15. Macro undefined: `start` in IDLE → `err`=1.
